// File: rtl/level_round_ctrl_if.sv
// Handshake bundle between the game FSM and level_round_ctrl: round control
// pulses in, round status and display counters out.
interface level_round_ctrl_if;
    logic       start;
    logic       hit;
    logic       death;
    logic [2:0] level;
    logic       level_passed;
    logic       level_failed;
    logic       game_over;
    logic       playing;
    logic [2:0] lives;
    logic [7:0] time_left;
    logic [7:0] hits;

    modport master (
        output start, hit, death, level,
        input  level_passed, level_failed, game_over, playing, lives, time_left, hits
    );

    modport slave (
        input  start, hit, death, level,
        output level_passed, level_failed, game_over, playing, lives, time_left, hits
    );
endinterface

// File: rtl/level_round_ctrl.sv
// Single level attempt: get-ready countdown, timed play window, hit quota and lives.
// Optional macro BONUS_LIFE_EN: passing with at least half the play time left awards a life.
module level_round_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int ROUND_TIME   = 30,
    parameter int READY_TICKS  = 3,
    parameter int HITS_TO_PASS = 4,
    parameter int START_LIVES  = 3
) (
    input  logic             clk,
    input  logic             reset,
    level_round_ctrl_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (READY_TICKS > 0) ? $clog2(READY_TICKS + 1) : 1;
`ifdef BONUS_LIFE_EN
    localparam logic [7:0] HALF_TIME = 8'(ROUND_TIME / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_PLAY     = 3'd2,
        S_PASS     = 3'd3,
        S_FAIL     = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [RW-1:0] r_ready_cnt;
    logic [2:0]    r_lives;
    logic [7:0]    r_time_left;
    logic [7:0]    r_hits;
    logic          r_passed;
    logic          r_failed;
    logic          r_game_over;
    logic          r_playing;

    logic          w_tick;
    logic [7:0]    w_hits_nxt;
    logic [7:0]    w_time_nxt;
    logic [7:0]    w_quota;
    logic          w_quota_met;
    logic          w_timeout;

    // Tick generation plus the PLAY-cycle counter updates and exit conditions.
    always_comb begin
        w_tick = 1'b0;
        if ((r_state == S_READY || r_state == S_PLAY) && r_presc == PW'(TICK_DIV - 1)) begin
            w_tick = 1'b1;
        end else begin
            w_tick = 1'b0;
        end
        w_hits_nxt = r_hits;
        if (bus.hit && r_hits != 8'd255) begin
            w_hits_nxt = r_hits + 8'd1;
        end else begin
            w_hits_nxt = r_hits;
        end
        w_time_nxt = r_time_left;
        if (w_tick && r_time_left != 8'd0) begin
            w_time_nxt = r_time_left - 8'd1;
        end else begin
            w_time_nxt = r_time_left;
        end
        // Quota wraps in 8 bits by design; level is zero-extended.
        w_quota     = 8'(HITS_TO_PASS) + {5'd0, bus.level};
        w_quota_met = bus.hit && (w_hits_nxt >= w_quota);
        w_timeout   = w_tick && (r_time_left == 8'd1);
    end

    // Round sequencer with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_ready_cnt <= '0;
            r_lives     <= 3'(START_LIVES);
            r_time_left <= 8'(ROUND_TIME);
            r_hits      <= 8'd0;
            r_passed    <= 1'b0;
            r_failed    <= 1'b0;
            r_game_over <= 1'b0;
            r_playing   <= 1'b0;
        end else begin
            r_passed <= 1'b0;
            r_failed <= 1'b0;
            if (r_state == S_READY || r_state == S_PLAY) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_READY;
                        r_presc     <= '0;
                        r_ready_cnt <= RW'(READY_TICKS);
                        r_time_left <= 8'(ROUND_TIME);
                        r_hits      <= 8'd0;
                    end
                end
                S_READY: begin
                    if (w_tick) begin
                        r_ready_cnt <= r_ready_cnt - RW'(1);
                        if (r_ready_cnt == RW'(1)) begin
                            r_state   <= S_PLAY;
                            r_playing <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    r_hits      <= w_hits_nxt;
                    r_time_left <= w_time_nxt;
                    if (bus.death || (!w_quota_met && w_timeout)) begin
                        r_state   <= S_FAIL;
                        r_playing <= 1'b0;
                        r_failed  <= 1'b1;
                        r_lives   <= (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                    end else if (w_quota_met) begin
                        r_state   <= S_PASS;
                        r_playing <= 1'b0;
                        r_passed  <= 1'b1;
`ifdef BONUS_LIFE_EN
                        if (w_time_nxt >= HALF_TIME && r_lives != 3'd7) begin
                            r_lives <= r_lives + 3'd1;
                        end
`endif
                    end
                end
                S_PASS: begin
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    // Lives were already decremented on entry, so zero means the last life went.
                    if (r_lives == 3'd0) begin
                        r_state     <= S_GAMEOVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAMEOVER: begin
                    r_lives <= 3'd0;
                    if (bus.start) begin
                        r_state     <= S_READY;
                        r_game_over <= 1'b0;
                        r_lives     <= 3'(START_LIVES);
                        r_presc     <= '0;
                        r_ready_cnt <= RW'(READY_TICKS);
                        r_time_left <= 8'(ROUND_TIME);
                        r_hits      <= 8'd0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_passed = r_passed;
    assign bus.level_failed = r_failed;
    assign bus.game_over    = r_game_over;
    assign bus.playing      = r_playing;
    assign bus.lives        = r_lives;
    assign bus.time_left    = r_time_left;
    assign bus.hits         = r_hits;
endmodule

// File: tb/tb_level_round_ctrl.sv
// Randomized and directed bench for level_round_ctrl against a cycle-count reference model.
module tb_level_round_ctrl;
    localparam int TD  = 4;
    localparam int RT  = 3;
    localparam int RDY = 2;
    localparam int HTP = 2;
    localparam int SL  = 3;

    localparam int P_IDLE = 0, P_READY = 1, P_PLAY = 2, P_PASS = 3, P_FAIL = 4, P_OVER = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int m_ph, m_cyc, m_lives, m_time, m_hits, m_pass, m_fail;

    level_round_ctrl_if bus();

    level_round_ctrl #(
        .TICK_DIV(TD), .ROUND_TIME(RT), .READY_TICKS(RDY),
        .HITS_TO_PASS(HTP), .START_LIVES(SL)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ph = P_IDLE; m_cyc = 0; m_lives = SL; m_time = RT; m_hits = 0; m_pass = 0; m_fail = 0;
    endfunction

    function automatic void round_start();
        m_ph = P_READY; m_cyc = 0; m_time = RT; m_hits = 0;
    endfunction

    // m_cyc counts clocks since the round began; ticks fall on multiples of TD.
    function automatic void model_step(input logic s, input logic h, input logic d, input logic [2:0] l);
        bit tick;
        m_pass = 0;
        m_fail = 0;
        case (m_ph)
            P_IDLE:  if (s) round_start();
            P_READY: begin
                m_cyc++;
                if (m_cyc == RDY * TD) m_ph = P_PLAY;
            end
            P_PLAY: begin
                m_cyc++;
                tick = (m_cyc % TD) == 0;
                if (h && m_hits < 255) m_hits++;
                m_time = RT - (m_cyc / TD - RDY);
                if (d) begin
                    m_fail = 1; m_ph = P_FAIL; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end else if (h && m_hits >= ((HTP + int'(l)) % 256)) begin
                    m_pass = 1; m_ph = P_PASS;
`ifdef BONUS_LIFE_EN
                    if (m_time >= RT / 2 && m_lives < 7) m_lives++;
`endif
                end else if (tick && m_time == 0) begin
                    m_fail = 1; m_ph = P_FAIL; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end
            end
            P_PASS:  m_ph = P_IDLE;
            P_FAIL:  m_ph = (m_lives == 0) ? P_OVER : P_IDLE;
            P_OVER:  if (s) begin m_lives = SL; round_start(); end
            default: m_ph = P_IDLE;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level_passed", int'(bus.level_passed), m_pass);
            chk("level_failed", int'(bus.level_failed), m_fail);
            chk("game_over", int'(bus.game_over), (m_ph == P_OVER) ? 1 : 0);
            chk("playing", int'(bus.playing), (m_ph == P_PLAY) ? 1 : 0);
            chk("lives", int'(bus.lives), m_lives);
            chk("time_left", int'(bus.time_left), m_time);
            chk("hits", int'(bus.hits), m_hits);
        end
    end

    task automatic step(input logic s, input logic h, input logic d, input logic [2:0] l);
        bus.start = s; bus.hit = h; bus.death = d; bus.level = l;
        @(posedge clk);
        if (rst_n) model_step(s, h, d, l);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(1);
        rst_n = 1'b1;
    endtask

    task automatic start_to_play(input logic [2:0] l);
        step(1'b1, 1'b0, 1'b0, l);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, l);
    endtask

    initial begin
        bus.start = 1'b0; bus.hit = 1'b0; bus.death = 1'b0; bus.level = 3'd0;
        model_reset();
        @(negedge clk); #1;
        chk("reset_lives", int'(bus.lives), 3);
        chk("reset_time", int'(bus.time_left), 3);
        chk("reset_playing", int'(bus.playing), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // No hits: countdown, play window, timeout.
        idle(2);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        idle(7);
        chk("t1_ready_7", int'(bus.playing), 0);
        idle(1);
        chk("t1_play_8", int'(bus.playing), 1);
        chk("t1_time3", int'(bus.time_left), 3);
        idle(4);
        chk("t1_time2", int'(bus.time_left), 2);
        idle(4);
        chk("t1_time1", int'(bus.time_left), 1);
        idle(4);
        chk("t1_time0", int'(bus.time_left), 0);
        chk("t1_failed", int'(bus.level_failed), 1);
        chk("t1_lives", int'(bus.lives), 2);
        idle(1);
        chk("t1_fail_pulse_end", int'(bus.level_failed), 0);

        // Three hits at level 1 pass the round.
        do_reset();
        start_to_play(3'd1);
        step(1'b0, 1'b1, 1'b0, 3'd1);
        step(1'b0, 1'b1, 1'b0, 3'd1);
        chk("t2_no_early_pass", int'(bus.level_passed), 0);
        step(1'b0, 1'b1, 1'b0, 3'd1);
        chk("t2_passed", int'(bus.level_passed), 1);
        chk("t2_hits", int'(bus.hits), 3);
`ifdef BONUS_LIFE_EN
        chk("t2_lives", int'(bus.lives), 4);
`else
        chk("t2_lives", int'(bus.lives), 3);
`endif
        idle(1);
        chk("t2_pass_pulse_end", int'(bus.level_passed), 0);

        // Death beats a quota-completing hit.
        do_reset();
        start_to_play(3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 3'd0);
        chk("t3_failed", int'(bus.level_failed), 1);
        chk("t3_not_passed", int'(bus.level_passed), 0);
        chk("t3_lives", int'(bus.lives), 2);

        // Three failed rounds end the game; start restarts it.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            start_to_play(3'd0);
            step(1'b0, 1'b0, 1'b1, 3'd0);
            idle(1);
        end
        chk("t4_game_over", int'(bus.game_over), 1);
        chk("t4_lives0", int'(bus.lives), 0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        chk("t4_restart_lives", int'(bus.lives), 3);
        chk("t4_restart_go", int'(bus.game_over), 0);
        idle(8);
        chk("t4_restart_play", int'(bus.playing), 1);

        // Quota met on the final timeout tick.
        do_reset();
        start_to_play(3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        idle(10);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        chk("t5_passed", int'(bus.level_passed), 1);
        chk("t5_failed", int'(bus.level_failed), 0);
        chk("t5_time0", int'(bus.time_left), 0);
        chk("t5_hits", int'(bus.hits), 2);

        // Asynchronous reset in the middle of PLAY.
        do_reset();
        start_to_play(3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        chk("t6_hits1", int'(bus.hits), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_playing", int'(bus.playing), 0);
        chk("t6_rst_hits", int'(bus.hits), 0);
        chk("t6_rst_time", int'(bus.time_left), 3);
        chk("t6_rst_lives", int'(bus.lives), 3);
        chk("t6_rst_pulses", int'(bus.level_passed) + int'(bus.level_failed) + int'(bus.game_over), 0);
        model_reset();
        idle(1);
        rst_n = 1'b1;

        // Random traffic, with an occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)));
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/level_round_ctrl.md
Name: level_round_ctrl

Overview:
Sequences a single level attempt for the game FSM. It runs a get-ready countdown, then a timed play window. It counts target hits against a level-scaled quota and tracks player lives. It emits a one-cycle level_passed pulse, which drives the game FSM's levelPassed input, or a level_failed / game_over indication, and holds the round timer and hit count for display logic.

Parameters:
TICK_DIV, 50_000_000, clk cycles per game tick (one second); must be >= 2
ROUND_TIME, 30, play window length in ticks, 1..255
READY_TICKS, 3, get-ready countdown length in ticks, >= 1
HITS_TO_PASS, 4, base hit quota; effective quota = HITS_TO_PASS + level
START_LIVES, 3, lives loaded at reset and on restart, 1..7

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a round (IDLE) or restarts the game (GAMEOVER)
hit  input  1  one-cycle pulse per target hit
death  input  1  one-cycle pulse when the player dies
level  input  3  current level from the game FSM, sampled every cycle in PLAY
level_passed  output  1  one-cycle pulse, round won
level_failed  output  1  one-cycle pulse, round lost
game_over  output  1  level, lives exhausted
playing  output  1  high while in PLAY
lives  output  3  remaining lives
time_left  output  8  remaining play ticks
hits  output  8  hits this round

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, lives=START_LIVES, time_left=ROUND_TIME, hits=0, prescaler=0, ready_cnt=0.
  - All pulse outputs, game_over and playing are 0.
  - Reset mid-round abandons the round with no pulse emitted.
- All outputs are registered or decoded from registered state; no combinational path from input to output.
- Prescaler:
  - Counts only in READY and PLAY; cleared on entry to READY.
  - tick=1 for one cycle when prescaler==TICK_DIV-1, then wraps to 0.
- States: IDLE, READY, PLAY, PASS, FAIL, GAMEOVER.
- IDLE:
  - On start: go to READY; load time_left=ROUND_TIME, hits=0, ready_cnt=READY_TICKS.
  - hit and death are ignored.
- READY: on each tick, ready_cnt decrements; a tick while ready_cnt==1 moves to PLAY. hit and death are ignored.
- PLAY:
  - playing=1.
  - hit increments hits, saturating at 255.
  - A tick decrements time_left.
- PLAY exit priority, evaluated in the same cycle:
  1. death: go to FAIL.
  2. hit with hits+1 >= HITS_TO_PASS+level: go to PASS.
  3. tick with time_left==1: time_left becomes 0, go to FAIL.
  - A hit and a timeout in the same cycle with the quota met resolve as PASS.
- PASS:
  - Lasts one cycle; level_passed=1; then go to IDLE.
  - Latency: the winning hit sampled at edge N gives level_passed high for the cycle after N.
  - hits and time_left hold their values until the next start.
- FAIL:
  - Lasts one cycle; level_failed=1; lives decrements, saturating at 0.
  - If lives==1 on entry, go to GAMEOVER; otherwise go to IDLE, and a retry requires start.
- GAMEOVER:
  - game_over=1; lives=0.
  - start reloads lives=START_LIVES and goes directly to READY, with the same loads as IDLE+start.
- start is ignored in READY, PLAY, PASS and FAIL.
- Quota arithmetic is 8-bit; level is zero-extended.

Optional Feature:
BONUS_LIFE_EN
- Defined: on entry to PASS, if time_left >= ROUND_TIME/2 (integer division) and lives<7, lives increments by 1 in the same cycle as level_passed.
- Undefined: lives never increases except through reset or restart.

Test Plan:
All scenarios use TICK_DIV=4, ROUND_TIME=3, READY_TICKS=2, HITS_TO_PASS=2, START_LIVES=3.
- Reset then start, with no hits: PLAY begins 8 cycles after start. time_left steps 3->2->1->0 every 4 cycles. level_failed pulses once, lives=2, state returns to IDLE.
- level=1, start, then 3 hit pulses in PLAY: the third hit gives level_passed high exactly 1 cycle after it, and hits=3. With BONUS_LIFE_EN and the hits landing before the first play tick, lives becomes 4.
- death and a quota-completing hit in the same cycle: level_failed=1, level_passed stays 0, lives decrements.
- Three consecutive failed rounds: game_over=1 and lives=0. A following start gives lives=3, game_over=0 and entry to READY.
- A quota-completing hit on the final timeout tick: PASS, and time_left=0.
- reset driven low during PLAY with hits=1: all outputs return to reset values within the same cycle, and no pulse is emitted.
